// File: rtl/ip_ram_arbiter.sv
// Round-robin two-port arbiter that sequences 32-bit word requests as four
// little-endian byte accesses on a single 8-bit RAM port.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and drives byte 0 at the grant edge
// ACCESS | driving bytes 1..3; cnt_q counts edges since the grant
// DRAIN  | read only: waiting for the last byte to return (RD_LATENCY-1 cycles)
// DONE   | one-cycle done pulse to the granted port; busy clears on exit
module ip_ram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              done0,
    output logic [31:0]       rdata0,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              done1,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_writedata,
    output logic              ram_write_enable,
    input  logic [7:0]        ram_readdata,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

    localparam logic [3:0] LAT      = 4'(RD_LATENCY);
    localparam logic [3:0] READ_END = 4'd3 + LAT;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]          ram_wd_q, ram_wd_d;
    logic                ram_we_q, ram_we_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic [31:0]         rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                busy_q, busy_d;
    logic                gid_q, gid_d;

    logic                gnt;
    logic [3:0]          step;
    logic [3:0]          cap_idx;
    logic [7:0]          wbyte;
    logic                fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_q     <= 1'b1;
            ram_addr_q <= '0;
            ram_wd_q   <= '0;
            ram_we_q   <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
            gid_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
            ram_addr_q <= ram_addr_d;
            ram_wd_q   <= ram_wd_d;
            ram_we_q   <= ram_we_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
            gid_q      <= gid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        ram_addr_d = ram_addr_q;
        ram_wd_d   = ram_wd_q;
        ram_we_d   = ram_we_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        busy_d     = busy_q;
        gid_d      = gid_q;

        // On a tie, the port that was not served last wins.
        gnt     = req1_valid & (~req0_valid | ~last_q);
        step    = {1'b0, cnt_q} + 4'd1;
        cap_idx = step - LAT;
        fin     = we_q | (READ_END == 4'd4);
        case (step[1:0])
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            2'd3:    wbyte = wdata_q[31:24];
            default: wbyte = wdata_q[7:0];
        endcase

        case (state_q)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    we_d       = gnt ? req1_we    : req0_we;
                    addr_d     = gnt ? req1_addr  : req0_addr;
                    wdata_d    = gnt ? req1_wdata : req0_wdata;
                    last_d     = gnt;
                    gid_d      = gnt;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = ACCESS;
                    ram_addr_d = addr_d;
                    ram_we_d   = we_d;
                    ram_wd_d   = we_d ? wdata_d[7:0] : 8'h00;
                end
            end
            ACCESS: begin
                cnt_d = step[2:0];
                if (step <= 4'd3) begin
                    ram_addr_d = addr_q + ADDR_W'(step);
                    ram_we_d   = we_q;
                    ram_wd_d   = we_q ? wbyte : 8'h00;
                end else begin
                    ram_addr_d = '0;
                    ram_we_d   = 1'b0;
                    ram_wd_d   = 8'h00;
                    if (fin) begin
                        state_d = DONE;
                        done0_d = ~gid_q;
                        done1_d = gid_q;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                cnt_d = step[2:0];
                if (step == READ_END) begin
                    state_d = DONE;
                    done0_d = ~gid_q;
                    done1_d = gid_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Byte k returns RD_LATENCY edges after its address was driven.
        if ((state_q == ACCESS || state_q == DRAIN) && !we_q &&
            step >= LAT && cap_idx <= 4'd3) begin
            if (gid_q)
                rdata1_d[{cap_idx[1:0], 3'b000} +: 8] = ram_readdata;
            else
                rdata0_d[{cap_idx[1:0], 3'b000} +: 8] = ram_readdata;
        end
    end

    assign done0            = done0_q;
    assign done1            = done1_q;
    assign rdata0           = rdata0_q;
    assign rdata1           = rdata1_q;
    assign ram_address      = ram_addr_q;
    assign ram_writedata    = ram_wd_q;
    assign ram_write_enable = ram_we_q;
    assign busy             = busy_q;
    assign grant_id         = gid_q;

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// Scoreboard bench for ip_ram_arbiter: expected RAM writes and done events are
// queued when a request is driven and checked as the DUT produces them.
module tb_ip_ram_arbiter;

    localparam int AW  = 19;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_we, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [31:0]   req0_wdata, req1_wdata;
    logic          done0, done1;
    logic [31:0]   rdata0, rdata1;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_writedata, ram_readdata;
    logic          ram_write_enable, busy, grant_id;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int grant_cyc = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [8:0]    data;
        logic [1:0]    port;
    } wr_t;

    typedef struct {
        logic [1:0]  port;
        logic [3:0]  lat;
        logic        chk_rd;
        logic [31:0] rdata;
    } dn_t;

    wr_t exp_w[$];
    dn_t exp_d[$];
    int  grant_cyc_q[$];
    int  grant_log[$];

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] rd_q;
    logic       busy_p = 1'b0, done0_p = 1'b0, done1_p = 1'b0;

    always #5 clk = ~clk;

    ip_ram_arbiter #(.ADDR_W(AW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .done0(done0), .rdata0(rdata0),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .done1(done1), .rdata1(rdata1),
        .ram_address(ram_address), .ram_writedata(ram_writedata),
        .ram_write_enable(ram_write_enable), .ram_readdata(ram_readdata),
        .busy(busy), .grant_id(grant_id)
    );

    // RAM model with a two-cycle read pipeline (address registered, data registered).
    always @(posedge clk) begin
        rd_q <= mem[ram_address];
        if (ram_write_enable) mem[ram_address] = ram_writedata;
        cyc <= cyc + 1;
    end
    assign ram_readdata = rd_q;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (busy && !busy_p) begin
            grant_cyc = cyc;
            grant_cyc_q.push_back(cyc);
            grant_log.push_back(int'(grant_id));
        end
        if (ram_write_enable) begin
            if (exp_w.size() > 0) w = exp_w.pop_front();
            else w = '{addr: '0, data: 9'h1FF, port: 2'd3};
            check("wr_addr", 64'(ram_address), 64'(w.addr));
            check("wr_data", 64'({1'b0, ram_writedata}), 64'(w.data));
            check("wr_port", 64'(grant_id), 64'(w.port));
        end
        if (done0 || done1) begin
            if (exp_d.size() > 0) d = exp_d.pop_front();
            else d = '{port: 2'd3, lat: 4'hF, chk_rd: 1'b0, rdata: '0};
            check("done_port", 64'({done1, done0}), 64'(2'b01 << d.port));
            check("done_latency", 64'(cyc - grant_cyc), 64'(d.lat));
            check("done_single", 64'({done1_p, done0_p}), 64'(2'b00));
            if (d.chk_rd) check("rdata", 64'(d.port == 2'd1 ? rdata1 : rdata0), 64'(d.rdata));
        end
        busy_p  <= busy;
        done0_p <= done0;
        done1_p <= done1;
    end

    task automatic start_req(input int p, input logic we, input logic [AW-1:0] a,
                             input logic [31:0] wd, input int nbytes, input bit exp_done);
        logic [31:0] rw;
        for (int k = 0; k < 4; k++) rw[8*k +: 8] = mem[a + AW'(k)];
        if (we) begin
            for (int k = 0; k < nbytes; k++)
                exp_w.push_back('{addr: a + AW'(k), data: {1'b0, wd[8*k +: 8]}, port: 2'(p)});
        end
        if (exp_done)
            exp_d.push_back('{port: 2'(p), lat: (we ? 4'd4 : 4'(3 + LAT)), chk_rd: ~we, rdata: rw});
        if (p == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = wd;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = wd;
        end
    endtask

    task automatic wait_done(input int p);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((p == 0) ? done0 : done1) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'(1));
    endtask

    task automatic wait_busy();
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("busy_seen", 64'(seen), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[19'h00200] = 8'h11; mem[19'h00201] = 8'h22;
        mem[19'h00202] = 8'h33; mem[19'h00203] = 8'h44;

        #12;
        check("rst_ram_address", 64'(ram_address), 64'(0));
        check("rst_ram_wdata", 64'(ram_writedata), 64'(0));
        check("rst_ram_we", 64'(ram_write_enable), 64'(0));
        check("rst_done", 64'({done1, done0}), 64'(0));
        check("rst_rdata0", 64'(rdata0), 64'(0));
        check("rst_rdata1", 64'(rdata1), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Single write from port 0
        @(posedge clk); #1 start_req(0, 1'b1, 19'h00100, 32'hDEADBEEF, 4, 1'b1);
        wait_done(0);
        check("w1_done1_quiet", 64'(done1), 64'(0));
        req0_valid = 1'b0;
        check("w1_mem", 64'({mem[19'h00103], mem[19'h00102], mem[19'h00101], mem[19'h00100]}),
              64'(32'hDEADBEEF));

        // Single read from port 1
        @(posedge clk); #1 start_req(1, 1'b0, 19'h00200, 32'h0, 4, 1'b1);
        wait_done(1);
        check("r1_rdata1", 64'(rdata1), 64'(32'h44332211));
        check("r1_rdata0_hold", 64'(rdata0), 64'(0));
        req1_valid = 1'b0;

        // Address wrap
        @(posedge clk); #1 start_req(0, 1'b1, 19'h7FFFE, 32'hA1B2C3D4, 4, 1'b1);
        wait_done(0);
        req0_valid = 1'b0;
        check("wrap_mem", 64'({mem[19'h00001], mem[19'h00000], mem[19'h7FFFF], mem[19'h7FFFE]}),
              64'(32'hA1B2C3D4));

        // Request fields change after the grant
        @(posedge clk); #1 start_req(1, 1'b1, 19'h00300, 32'h12345678, 4, 1'b1);
        wait_busy();
        req1_addr = 19'h00400; req1_wdata = 32'hFFFFFFFF; req1_we = 1'b0;
        wait_done(1);
        req1_valid = 1'b0;
        check("chg_mem_new_addr", 64'(mem[19'h00400]), 64'(0));

        // Reset in the middle of a write
        for (int k = 0; k < 4; k++) mem[19'h00500 + 19'(k)] = 8'h55;
        @(posedge clk); #1 start_req(0, 1'b1, 19'h00500, 32'hCAFEF00D, 2, 1'b0);
        wait_busy();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0; req0_valid = 1'b0;
        #1;
        check("rstmid_ram_we", 64'(ram_write_enable), 64'(0));
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_done0", 64'(done0), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        check("rstmid_mem", 64'({mem[19'h00503], mem[19'h00502], mem[19'h00501], mem[19'h00500]}),
              64'(32'h5555F00D));
        check("rstmid_wr_left", 64'(exp_w.size()), 64'(0));

        // Contention from reset: grants must alternate starting with port 0
        grant_cyc_q.delete();
        grant_log.delete();
        @(posedge clk); #1;
        start_req(0, 1'b1, 19'h00600, 32'h0A0B0C0D, 4, 1'b1);
        start_req(1, 1'b1, 19'h00700, 32'h1A1B1C1D, 4, 1'b1);
        start_req(0, 1'b1, 19'h00600, 32'h0A0B0C0D, 4, 1'b1);
        start_req(1, 1'b1, 19'h00700, 32'h1A1B1C1D, 4, 1'b1);
        wait_done(0);
        wait_done(1);
        wait_done(0);
        wait_done(1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("cont_grants", 64'(grant_log.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            check("cont_grant_order", 64'(grant_log[i]), 64'(i % 2));
        for (int i = 1; i < 4; i++)
            check("cont_grant_spacing", 64'(grant_cyc_q[i] - grant_cyc_q[i-1]), 64'(6));

        repeat (8) @(posedge clk);
        #1;
        check("end_busy", 64'(busy), 64'(0));
        check("end_wr_left", 64'(exp_w.size()), 64'(0));
        check("end_done_left", 64'(exp_d.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
